// File: rtl/cnn1d_pkg.sv
// Shared types and defaults for the 1-D CNN datapath blocks.
package cnn1d_pkg;
  localparam int DATA_WIDTH      = 8;
  localparam int KERNEL_SIZE_DEF = 3;
  localparam int STRIDE_DEF      = 1;

  typedef enum logic {
    FILL,
    RUN
  } WINDOW_FSM_T;
endpackage

// File: rtl/conv1d_window_if.sv
// Sample-in / window-out stream bundle; slave is the window block, master its environment.
interface conv1d_window_if
  import cnn1d_pkg::*;
#(
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF
) ();
  logic [DATA_WIDTH-1:0]                   in_data;
  logic                                    in_valid;
  logic                                    in_last;
  logic                                    in_ready;
  logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0]  out_win;
  logic                                    out_valid;
  logic                                    out_last;
  logic                                    out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_win, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_win, out_valid, out_last
  );
endinterface

// File: rtl/conv1d_window_outreg.sv
// Single-entry held output register with valid/ready; a load in the consume cycle wins.
module conv1d_window_outreg #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_last
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;
endmodule

// File: rtl/conv1d_window.sv
// Sliding-window former: serial samples in, KERNEL_SIZE-wide windows out every STRIDE samples.
// Optional causal zero padding is enabled with `define CONV1D_WINDOW_CAUSAL_PAD_EN.
module conv1d_window
  import cnn1d_pkg::*;
#(
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int STRIDE      = STRIDE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  conv1d_window_if.slave   bus,
  output logic             short_frame
);
  localparam int FW = $clog2(KERNEL_SIZE + 1);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [FW-1:0] FILL_K     = FW'(KERNEL_SIZE);
  localparam logic [SW-1:0] STRIDE_MAX = SW'(STRIDE - 1);
`ifdef CONV1D_WINDOW_CAUSAL_PAD_EN
  localparam logic [FW-1:0] FILL_INIT  = FW'(KERNEL_SIZE - 1);
`else
  localparam logic [FW-1:0] FILL_INIT  = '0;
`endif

  WINDOW_FSM_T                            r_state, w_state_next;
  logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] r_win, w_win_next, w_win_shift;
  logic [FW-1:0]                          r_fill, w_fill_next, w_fill_inc;
  logic [SW-1:0]                          r_stride, w_stride_next, w_stride_inc;
  logic                                   r_short, w_short_next;
  logic                                   w_load;
  logic                                   w_accept;
  logic                                   w_in_ready;
  logic                                   w_out_valid;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0]      w_out_win;

  assign w_in_ready = !w_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  generate
    for (genvar gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_shift
      assign w_win_shift[gi] = r_win[gi+1];
    end
  endgenerate
  assign w_win_shift[KERNEL_SIZE-1] = bus.in_data;

  assign w_fill_inc   = r_fill + 1'b1;
  assign w_stride_inc = (r_stride == STRIDE_MAX) ? '0 : r_stride + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= FILL;
      r_win    <= '0;
      r_fill   <= FILL_INIT;
      r_stride <= '0;
      r_short  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_win    <= w_win_next;
      r_fill   <= w_fill_next;
      r_stride <= w_stride_next;
      r_short  <= w_short_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_win_next    = r_win;
    w_fill_next   = r_fill;
    w_stride_next = r_stride;
    w_short_next  = 1'b0;
    w_load        = 1'b0;
    if (w_accept) begin
      w_win_next = w_win_shift;
      case (r_state)
        FILL: begin
          w_fill_next = w_fill_inc;
          if (w_fill_inc == FILL_K) begin
            w_load        = 1'b1;
            w_state_next  = RUN;
            w_stride_next = '0;
          end
        end
        RUN: begin
          w_stride_next = w_stride_inc;
          w_load        = (w_stride_inc == '0);
        end
        default: w_state_next = FILL;
      endcase
      // Frame end: restart filling; the emitted window (if any) already took the shifted data.
      if (bus.in_last) begin
        w_fill_next   = FILL_INIT;
        w_stride_next = '0;
        w_state_next  = FILL;
`ifdef CONV1D_WINDOW_CAUSAL_PAD_EN
        w_win_next    = '0;
`else
        w_short_next  = (r_state == FILL) && !w_load;
`endif
      end
    end
  end

  conv1d_window_outreg #(
    .WIDTH (KERNEL_SIZE * DATA_WIDTH)
  ) u_outreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_win_shift),
    .i_last  (bus.in_last),
    .i_ready (bus.out_ready),
    .o_data  (w_out_win),
    .o_valid (w_out_valid),
    .o_last  (bus.out_last)
  );

  assign bus.out_win   = w_out_win;
  assign bus.out_valid = w_out_valid;
  assign bus.in_ready  = w_in_ready;
  assign short_frame   = r_short;
endmodule

// File: tb/tb_conv1d_window.sv
// Bench for conv1d_window: K=3 with STRIDE=1 (dut0) and STRIDE=2 (dut1), table rows plus hand sequences.
module tb_conv1d_window;
  import cnn1d_pkg::*;

  typedef struct {
    logic [23:0] win;
    logic        last;
  } exp_t;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic        last;
    int          hold;
    logic        emit;
    logic [23:0] win;
    logic        wlast;
    logic        shrt;
  } row_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sf0, sf1;
  logic [7:0] d_data  [2];
  logic       d_valid [2];
  logic       d_last  [2];
  logic       d_ordy  [2];
  logic       sf_exp  [2];
  bit         rst_active = 1'b1;
  int         total = 0;
  int         bad = 0;
  exp_t       sb0[$];
  exp_t       sb1[$];
  row_t       tbl[$];

  always #5 clk = ~clk;

  conv1d_window_if #(.KERNEL_SIZE(3)) if0 ();
  conv1d_window_if #(.KERNEL_SIZE(3)) if1 ();

  assign if0.in_data   = d_data[0];
  assign if0.in_valid  = d_valid[0];
  assign if0.in_last   = d_last[0];
  assign if0.out_ready = d_ordy[0];
  assign if1.in_data   = d_data[1];
  assign if1.in_valid  = d_valid[1];
  assign if1.in_last   = d_last[1];
  assign if1.out_ready = d_ordy[1];

  conv1d_window #(.KERNEL_SIZE(3), .STRIDE(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0), .short_frame(sf0)
  );
  conv1d_window #(.KERNEL_SIZE(3), .STRIDE(2)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1), .short_frame(sf1)
  );

  function automatic logic [23:0] w3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {a, b, c};
  endfunction

  task automatic cmp(input string name, input int d, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic add(input int d, input logic [7:0] data, input logic last, input int hold,
                     input logic emit, input logic [23:0] win, input logic wlast, input logic shrt);
    row_t r;
    r.dut = d; r.data = data; r.last = last; r.hold = hold;
    r.emit = emit; r.win = win; r.wlast = wlast; r.shrt = shrt;
    tbl.push_back(r);
  endtask

  task automatic check(input int d, input logic ov, input logic ordy, input logic irdy,
                       input logic [23:0] w, input logic ol, input logic sf);
    exp_t f;
    int   sz;
    f.win  = '0;
    f.last = 1'b0;
    if (d == 0) begin
      sz = sb0.size();
      if (sz > 0) f = sb0[0];
    end else begin
      sz = sb1.size();
      if (sz > 0) f = sb1[0];
    end
    cmp("out_valid", d, {23'd0, ov}, {23'd0, (sz != 0)});
    cmp("in_ready", d, {23'd0, irdy}, {23'd0, ((sz == 0) || ordy)});
    cmp("short_frame", d, {23'd0, sf}, {23'd0, sf_exp[d]});
    sf_exp[d] = 1'b0;
    if (sz > 0 && ov) begin
      cmp("out_win", d, w, f.win);
      cmp("out_last", d, {23'd0, ol}, {23'd0, f.last});
      if (ordy) begin
        $display("dut%0d window %h last=%0b consumed", d, w, ol);
        if (d == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_active) begin
      check(0, if0.out_valid, if0.out_ready, if0.in_ready, if0.out_win, if0.out_last, sf0);
      check(1, if1.out_valid, if1.out_ready, if1.in_ready, if1.out_win, if1.out_last, sf1);
    end
  end

  // Called at posedge+1; returns at the next posedge+1 with valid dropped.
  task automatic send(input int d, input logic [7:0] data, input logic last, input int hold,
                      input logic emit, input logic [23:0] win, input logic wlast, input logic shrt);
    bit   got;
    exp_t e;
    d_data[d]  = data;
    d_valid[d] = 1'b1;
    d_last[d]  = last;
    if (hold > 0) begin
      d_ordy[d] = 1'b0;
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1;
      d_ordy[d] = 1'b1;
    end
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if ((d == 0) ? if0.in_ready : if1.in_ready) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dut%0d: sample %0d not accepted within 50 cycles", d, data);
    end else begin
      #1;
      e.win  = win;
      e.last = wlast;
      if (emit) begin
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
      if (shrt) sf_exp[d] = 1'b1;
      $display("dut%0d sample %0d last=%0b accepted", d, data, last);
    end
    @(posedge clk);
    #1;
    d_valid[d] = 1'b0;
    d_last[d]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      d_data[i] = '0; d_valid[i] = 1'b0; d_last[i] = 1'b0; d_ordy[i] = 1'b1; sf_exp[i] = 1'b0;
    end

`ifdef CONV1D_WINDOW_CAUSAL_PAD_EN
    add(0, 1, 0, 0, 1, w3(0,0,1), 0, 0);
    add(0, 2, 0, 0, 1, w3(0,1,2), 0, 0);
    add(0, 3, 0, 0, 1, w3(1,2,3), 0, 0);
    add(0, 4, 0, 0, 1, w3(2,3,4), 0, 0);
    add(0, 5, 0, 0, 1, w3(3,4,5), 0, 0);
    add(0, 6, 1, 0, 1, w3(4,5,6), 1, 0);
    add(0, 1, 0, 0, 1, w3(0,0,1), 0, 0);
    add(0, 2, 0, 0, 1, w3(0,1,2), 0, 0);
    add(0, 3, 0, 0, 1, w3(1,2,3), 0, 0);
    add(0, 4, 0, 4, 1, w3(2,3,4), 0, 0);
    add(0, 5, 1, 0, 1, w3(3,4,5), 1, 0);
    add(0, 1, 0, 0, 1, w3(0,0,1), 0, 0);
    add(0, 2, 1, 0, 1, w3(0,1,2), 1, 0);
    add(0, 5, 0, 0, 1, w3(0,0,5), 0, 0);
    add(0, 6, 0, 0, 1, w3(0,5,6), 0, 0);
    add(0, 7, 1, 0, 1, w3(5,6,7), 1, 0);
    add(1, 1, 0, 0, 1, w3(0,0,1), 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 1, w3(1,2,3), 0, 0);
    add(1, 4, 0, 0, 0, 0, 0, 0);
    add(1, 5, 0, 0, 1, w3(3,4,5), 0, 0);
    add(1, 6, 0, 0, 0, 0, 0, 0);
    add(1, 7, 1, 0, 1, w3(5,6,7), 1, 0);
    add(1, 8, 0, 0, 1, w3(0,0,8), 0, 0);
    add(1, 9, 0, 0, 0, 0, 0, 0);
    add(1, 10, 1, 0, 1, w3(8,9,10), 1, 0);
`else
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0, 0, 0);
    add(0, 3, 0, 0, 1, w3(1,2,3), 0, 0);
    add(0, 4, 0, 0, 1, w3(2,3,4), 0, 0);
    add(0, 5, 0, 0, 1, w3(3,4,5), 0, 0);
    add(0, 6, 1, 0, 1, w3(4,5,6), 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0, 0, 0);
    add(0, 3, 0, 0, 1, w3(1,2,3), 0, 0);
    add(0, 4, 0, 4, 1, w3(2,3,4), 0, 0);
    add(0, 5, 1, 0, 1, w3(3,4,5), 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 2, 1, 0, 0, 0, 0, 1);
    add(0, 5, 0, 0, 0, 0, 0, 0);
    add(0, 6, 0, 0, 0, 0, 0, 0);
    add(0, 7, 1, 0, 1, w3(5,6,7), 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 1, w3(1,2,3), 0, 0);
    add(1, 4, 0, 0, 0, 0, 0, 0);
    add(1, 5, 0, 0, 1, w3(3,4,5), 0, 0);
    add(1, 6, 0, 0, 0, 0, 0, 0);
    add(1, 7, 1, 0, 1, w3(5,6,7), 1, 0);
    add(1, 8, 0, 0, 0, 0, 0, 0);
    add(1, 9, 0, 0, 0, 0, 0, 0);
    add(1, 10, 1, 0, 1, w3(8,9,10), 1, 0);
`endif

    // Reset state while held in reset.
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_out_valid", 0, {23'd0, if0.out_valid}, 24'd0);
    cmp("rst_out_win", 0, if0.out_win, 24'd0);
    cmp("rst_out_last", 0, {23'd0, if0.out_last}, 24'd0);
    cmp("rst_short", 0, {23'd0, sf0}, 24'd0);
    cmp("rst_in_ready", 0, {23'd0, if0.in_ready}, 24'd1);
    cmp("rst_out_valid", 1, {23'd0, if1.out_valid}, 24'd0);
    cmp("rst_in_ready", 1, {23'd0, if1.in_ready}, 24'd1);
    rst = 1'b1;
    rst_active = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      send(tbl[i].dut, tbl[i].data, tbl[i].last, tbl[i].hold,
           tbl[i].emit, tbl[i].win, tbl[i].wlast, tbl[i].shrt);

    // Reset with a window pending and downstream stalled.
    d_ordy[0] = 1'b0;
`ifdef CONV1D_WINDOW_CAUSAL_PAD_EN
    send(0, 1, 0, 0, 1, w3(0,0,1), 0, 0);
`else
    send(0, 1, 0, 0, 0, 0, 0, 0);
    send(0, 2, 0, 0, 0, 0, 0, 0);
    send(0, 3, 0, 0, 1, w3(1,2,3), 0, 0);
`endif
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_active = 1'b1;
    rst = 1'b0;
    #1;
    cmp("async_rst_out_valid", 0, {23'd0, if0.out_valid}, 24'd0);
    cmp("async_rst_out_win", 0, if0.out_win, 24'd0);
    cmp("async_rst_in_ready", 0, {23'd0, if0.in_ready}, 24'd1);
    sb0.delete();
    sb1.delete();
    sf_exp[0] = 1'b0;
    sf_exp[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    d_ordy[0] = 1'b1;
    rst = 1'b1;
    rst_active = 1'b0;
    @(posedge clk);
    #1;
`ifdef CONV1D_WINDOW_CAUSAL_PAD_EN
    send(0, 4, 0, 0, 1, w3(0,0,4), 0, 0);
    send(0, 5, 0, 0, 1, w3(0,4,5), 0, 0);
`else
    send(0, 4, 0, 0, 0, 0, 0, 0);
    send(0, 5, 0, 0, 0, 0, 0, 0);
`endif
    send(0, 6, 1, 0, 1, w3(4,5,6), 1, 0);

    repeat (5) @(posedge clk);
    #1;
    cmp("drain_dut0", 0, 24'(sb0.size()), 24'd0);
    cmp("drain_dut1", 1, 24'(sb1.size()), 24'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
